// File: rtl/aes_job_ctrl_if.sv
// rtl/aes_job_ctrl_if.sv - job/result handshake and AES core register bus for aes_job_ctrl
interface aes_job_ctrl_if;
    logic         job_valid;
    logic         job_ready;
    logic [127:0] job_plain;
    logic [255:0] job_key;
    logic [1:0]   job_keylen;
    logic         job_enc;
    logic         job_rekey;
    logic         res_valid;
    logic         res_ready;
    logic [127:0] res_data;
    logic         res_err;
    logic         busy;
    logic [6:0]   ADDR;
    logic [7:0]   DIN;
    logic         WR;
    logic         START;
    logic         OK;
    logic [7:0]   DOUT;

    // master is the sequencer: it serves the job port and masters the core bus
    modport master (
        input  job_valid, job_plain, job_key, job_keylen, job_enc, job_rekey,
        input  res_ready, OK, DOUT,
        output job_ready, res_valid, res_data, res_err, busy,
        output ADDR, DIN, WR, START
    );

    modport slave (
        output job_valid, job_plain, job_key, job_keylen, job_enc, job_rekey,
        output res_ready, OK, DOUT,
        input  job_ready, res_valid, res_data, res_err, busy,
        input  ADDR, DIN, WR, START
    );
endinterface

// File: rtl/aes_job_ctrl.sv
// rtl/aes_job_ctrl.sv - single-job sequencer driving the byte-addressed AES core register bus
module aes_job_ctrl #(
    parameter int TIMEOUT = 1023
) (
    input  logic           CLK,
    input  logic           RSTB,
    aes_job_ctrl_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, LD_DATA, LD_KEY, WR_CTRL, WR_CFG, GO, WAIT_LO, WAIT_HI, RD, DONE
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [127:0]   plain_q, plain_d;
    logic [255:0]   key_q, key_d;
    logic [1:0]     keylen_q, keylen_d;
    logic           enc_q, enc_d;
    logic           rekey_q, rekey_d;
    logic [127:0]   data_q, data_d;
    logic           err_q, err_d;
    logic [6:0]     addr_q, addr_d;
    logic [7:0]     din_q, din_d;
    logic           wr_q, wr_d;
    logic           start_q, start_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic [3:0]     rd_byte;

    // DOUT lags ADDR by one cycle, so RD step k captures the byte addressed at step k-1
    assign rd_byte = cnt_q[3:0] - 4'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        plain_d  = plain_q;
        key_d    = key_q;
        keylen_d = keylen_q;
        enc_d    = enc_q;
        rekey_d  = rekey_q;
        data_d   = data_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (bus.job_valid) begin
                    plain_d  = bus.job_plain;
                    key_d    = bus.job_key;
                    keylen_d = bus.job_keylen;
                    enc_d    = bus.job_enc;
                    rekey_d  = bus.job_rekey;
                    cnt_d    = 6'd0;
                    state_d  = LD_DATA;
                end
            end
            LD_DATA: begin
                if (cnt_q == 6'd15) begin
                    cnt_d   = 6'd0;
                    state_d = rekey_q ? LD_KEY : WR_CTRL;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            LD_KEY: begin
                if (cnt_q == 6'd31) begin
                    cnt_d   = 6'd0;
                    state_d = WR_CTRL;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            WR_CTRL: state_d = rekey_q ? WR_CFG : GO;
            WR_CFG:  state_d = GO;
            GO: begin
                tmo_d   = '0;
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                tmo_d = tmo_q + TW'(1);
                if (tmo_d == TW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (!bus.OK) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                tmo_d = tmo_q + TW'(1);
                if (bus.OK) begin
                    cnt_d   = 6'd0;
                    state_d = RD;
                end else if (tmo_d == TW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            RD: begin
                if (cnt_q != 6'd0) begin
                    data_d[{rd_byte, 3'b000} +: 8] = bus.DOUT;
                end
                if (cnt_q == 6'd16) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus outputs are decoded from the next state so they line up with it once registered
        wr_d   = 1'b0;
        addr_d = 7'd0;
        din_d  = 8'd0;
        case (state_d)
            LD_DATA: begin
                wr_d   = 1'b1;
                addr_d = {3'b000, cnt_d[3:0]};
                din_d  = plain_d[{cnt_d[3:0], 3'b000} +: 8];
            end
            LD_KEY: begin
                wr_d   = 1'b1;
                addr_d = {2'b01, cnt_d[4:0]};
                din_d  = key_d[{cnt_d[4:0], 3'b000} +: 8];
            end
            WR_CTRL: begin
                wr_d   = 1'b1;
                addr_d = 7'd64;
                din_d  = {7'b0, enc_d};
            end
            WR_CFG: begin
                wr_d   = 1'b1;
                addr_d = 7'd65;
                din_d  = {6'b0, keylen_d};
            end
            RD:      addr_d = {3'b001, cnt_d[3:0]};
            default: ;
        endcase
        start_d = (state_d == GO);
        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tmo_q    <= '0;
            plain_q  <= '0;
            key_q    <= '0;
            keylen_q <= '0;
            enc_q    <= 1'b0;
            rekey_q  <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            wr_q     <= 1'b0;
            start_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            plain_q  <= plain_d;
            key_q    <= key_d;
            keylen_q <= keylen_d;
            enc_q    <= enc_d;
            rekey_q  <= rekey_d;
            data_q   <= data_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            wr_q     <= wr_d;
            start_q  <= start_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.job_ready = (state_q == IDLE);
    assign bus.res_valid = valid_q;
    assign bus.res_data  = data_q;
    assign bus.res_err   = err_q;
    assign bus.busy      = busy_q;
    assign bus.ADDR      = addr_q;
    assign bus.DIN       = din_q;
    assign bus.WR        = wr_q;
    assign bus.START     = start_q;
endmodule

// File: tb/tb_aes_job_ctrl.sv
// tb/tb_aes_job_ctrl.sv - directed self-checking bench for aes_job_ctrl with a behavioural core model
module tb_aes_job_ctrl;
    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    aes_job_ctrl_if bus();

    aes_job_ctrl #(.TIMEOUT(1023)) dut (
        .CLK  (clk),
        .RSTB (rstb),
        .bus  (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Core model: result byte k = data[k] ^ key[k] ^ 8'hA5 ^ enc
    logic [7:0] core_mem [0:127];
    logic       core_ok   = 1'b0;
    logic [7:0] core_dout = 8'd0;
    int         ok_delay  = 20;
    int         stale_len = 0;
    bit         ok_never  = 1'b0;
    int         run_n     = 0;
    bit         running   = 1'b0;

    assign bus.OK   = core_ok;
    assign bus.DOUT = core_dout;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.WR) core_mem[bus.ADDR] <= bus.DIN;
        core_dout <= core_mem[bus.ADDR];
        if (bus.START) begin
            for (int i = 0; i < 16; i++)
                core_mem[16+i] <= core_mem[i] ^ core_mem[32+i] ^ 8'hA5 ^ {7'b0, core_mem[64][0]};
            run_n   <= 1;
            running <= 1'b1;
            if (stale_len == 0) core_ok <= 1'b0;
        end else if (running) begin
            run_n <= run_n + 1;
            if (run_n == stale_len - 1) core_ok <= 1'b0;
            if (run_n == ok_delay - 1 && !ok_never) begin
                core_ok <= 1'b1;
                running <= 1'b0;
            end
        end
    end

    int         nwr;
    logic [6:0] wr_addr [0:127];
    logic [7:0] wr_data [0:127];
    int         wr_cyc  [0:127];
    int         start_c, rd_first, rd_n, rise_c, valid_c;

    localparam logic [127:0] P1 = 128'h1234567890ABCDEF01234567899ABCDE;
    localparam logic [255:0] K1 = 256'h112233445566778899AABBCCDDEEFF00;
    localparam logic [127:0] P2 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] P3 = 128'hFEDCBA98765432100F1E2D3C4B5A6978;
    localparam logic [127:0] P4 = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;
    localparam logic [127:0] P6 = 128'hA5A5A5A55A5A5A5AC3C3C3C33C3C3C3C;
    localparam logic [255:0] K2 = 256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_res(input logic [127:0] p, input logic [255:0] k, input logic e);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = p[8*i +: 8] ^ k[8*i +: 8] ^ 8'hA5 ^ {7'b0, e};
        return r;
    endfunction

    task automatic offer_job(input logic [127:0] p, input logic [255:0] k, input logic [1:0] kl,
                             input logic e, input logic rk);
        @(negedge clk);
        bus.job_plain  = p;
        bus.job_key    = k;
        bus.job_keylen = kl;
        bus.job_enc    = e;
        bus.job_rekey  = rk;
        bus.job_valid  = 1'b1;
        @(negedge clk);
        bus.job_valid  = 1'b0;
    endtask

    // Logs bus activity, stamped relative to the accept cycle, until res_valid or the budget runs out
    task automatic run_job(input logic [127:0] p, input logic [255:0] k, input logic [1:0] kl,
                           input logic e, input logic rk);
        int  c0;
        int  n;
        int  guard;
        logic prev_ok;
        offer_job(p, k, kl, e, rk);
        c0 = cyc - 1;
        nwr = 0; start_c = -1; rd_first = -1; rd_n = 0; rise_c = -1;
        prev_ok = bus.OK;
        guard = 0;
        while (!bus.res_valid && guard < 3000) begin
            n = cyc - c0;
            if (bus.WR && nwr < 128) begin
                wr_addr[nwr] = bus.ADDR; wr_data[nwr] = bus.DIN; wr_cyc[nwr] = n; nwr++;
            end
            if (bus.START) start_c = n;
            if (!bus.WR && bus.busy && bus.ADDR >= 7'd16 && bus.ADDR < 7'd32) begin
                rd_n++;
                if (rd_first < 0) rd_first = n;
            end
            if (bus.OK && !prev_ok) rise_c = n;
            prev_ok = bus.OK;
            @(negedge clk);
            guard++;
        end
        valid_c = cyc - c0;
        check_val("res_valid_seen", bus.res_valid, 1'b1);
    endtask

    task automatic check_writes(input logic [127:0] p, input logic [255:0] k, input logic [1:0] kl,
                                input logic e, input logic rk);
        int nd;
        nd = rk ? 48 : 16;
        check_val("wr_count", nwr, rk ? 50 : 17);
        for (int i = 0; i < nd; i++) begin
            check_val($sformatf("wr%0d_addr", i), wr_addr[i], (i < 16) ? i : i + 16);
            check_val($sformatf("wr%0d_data", i), wr_data[i], (i < 16) ? p[8*i +: 8] : k[8*(i-16) +: 8]);
            check_val($sformatf("wr%0d_cyc", i), wr_cyc[i], i + 1);
        end
        check_val("ctrl_addr", wr_addr[nd], 64);
        check_val("ctrl_data", wr_data[nd], {7'b0, e});
        check_val("ctrl_cyc", wr_cyc[nd], nd + 1);
        if (rk) begin
            check_val("cfg_addr", wr_addr[nd+1], 65);
            check_val("cfg_data", wr_data[nd+1], {6'b0, kl});
            check_val("cfg_cyc", wr_cyc[nd+1], nd + 2);
        end
        check_val("start_cyc", start_c, rk ? 51 : 18);
    endtask

    task automatic finish_job(input int hold, input logic [127:0] exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_valid", bus.res_valid, 1'b1);
            check_val("hold_data", bus.res_data, exp);
            check_val("hold_jready", bus.job_ready, 1'b0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check_val("ack_jready", bus.job_ready, 1'b1);
        check_val("ack_valid", bus.res_valid, 1'b0);
        check_val("ack_busy", bus.busy, 1'b0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_wr"}, bus.WR, 1'b0);
        check_val({tag, "_start"}, bus.START, 1'b0);
        check_val({tag, "_addr"}, bus.ADDR, 7'd0);
        check_val({tag, "_din"}, bus.DIN, 8'd0);
        check_val({tag, "_valid"}, bus.res_valid, 1'b0);
        check_val({tag, "_err"}, bus.res_err, 1'b0);
        check_val({tag, "_data"}, bus.res_data, 128'd0);
        check_val({tag, "_busy"}, bus.busy, 1'b0);
        check_val({tag, "_jready"}, bus.job_ready, 1'b1);
    endtask

    initial begin
        logic [127:0] exp1, exp2, exp3, exp6;
        bus.job_valid = 1'b0; bus.job_plain = '0; bus.job_key = '0;
        bus.job_keylen = 2'd0; bus.job_enc = 1'b0; bus.job_rekey = 1'b0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        rstb = 1'b1;
        @(negedge clk);

        exp1 = model_res(P1, K1, 1'b1);
        run_job(P1, K1, 2'd3, 1'b1, 1'b1);
        check_writes(P1, K1, 2'd3, 1'b1, 1'b1);
        check_val("j1_rd_first", rd_first, rise_c + 1);
        check_val("j1_valid_cyc", valid_c, rise_c + 18);
        check_val("j1_data", bus.res_data, exp1);
        check_val("j1_err", bus.res_err, 1'b0);
        finish_job(10, exp1);

        exp2 = model_res(P2, K1, 1'b0);
        run_job(P2, '0, 2'd1, 1'b0, 1'b0);
        check_writes(P2, '0, 2'd1, 1'b0, 1'b0);
        check_val("j2_rd_first", rd_first, rise_c + 1);
        check_val("j2_data", bus.res_data, exp2);
        check_val("j2_err", bus.res_err, 1'b0);
        finish_job(0, exp2);

        stale_len = 5;
        exp3 = model_res(P3, K1, 1'b1);
        run_job(P3, '0, 2'd1, 1'b1, 1'b0);
        check_val("j3_start", start_c, 18);
        check_val("j3_rd_first", rd_first, start_c + 21);
        check_val("j3_valid_cyc", valid_c, start_c + 38);
        check_val("j3_data", bus.res_data, exp3);
        finish_job(0, exp3);

        stale_len = 0;
        ok_never  = 1'b1;
        run_job(P4, '0, 2'd1, 1'b1, 1'b0);
        check_val("to_valid_cyc", valid_c, start_c + 1024);
        check_val("to_err", bus.res_err, 1'b1);
        check_val("to_data", bus.res_data, exp3);
        check_val("to_no_rd", rd_n, 0);
        finish_job(0, exp3);
        ok_never = 1'b0;

        offer_job(P6, K2, 2'd1, 1'b1, 1'b1);
        repeat (29) @(negedge clk);
        check_val("pre_rst_wr", bus.WR, 1'b1);
        rstb = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        check_val("post_rst_jready", bus.job_ready, 1'b1);
        check_val("post_rst_busy", bus.busy, 1'b0);
        check_val("post_rst_wr", bus.WR, 1'b0);

        exp6 = model_res(P6, K2, 1'b1);
        run_job(P6, K2, 2'd1, 1'b1, 1'b1);
        check_writes(P6, K2, 2'd1, 1'b1, 1'b1);
        check_val("j6_rd_first", rd_first, rise_c + 1);
        check_val("j6_data", bus.res_data, exp6);
        check_val("j6_err", bus.res_err, 1'b0);
        finish_job(0, exp6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_job_ctrl.md
# aes_job_ctrl

Host-side job sequencer for the byte-addressed AES core (`TOP`). It accepts one encrypt/decrypt job at a time on a valid/ready port and drives the core's register bus (`ADDR`/`DIN`/`WR`) to load the data block and, optionally, the key. It then pulses `START`, waits for `OK`, reads back the 16 result bytes and presents them as one 128-bit result. It sits between the system-side requester and the core and is the only master of the core bus.

## Interface

- `TIMEOUT`, default 1023: maximum number of cycles spent in the wait states before the job is aborted with an error.
- `CLK` in 1: clock; all logic is on the rising edge.
- `RSTB` in 1: asynchronous, active-low reset.
- `job_valid` in 1: a job is offered.
- `job_ready` out 1: high only in IDLE.
- `job_plain` in 128: input block; byte k is `job_plain[8k+7:8k]`.
- `job_key` in 256: key; byte k is `job_key[8k+7:8k]`.
- `job_keylen` in 2: key length code: 1 = 128-bit, 2 = 192-bit, 3 = 256-bit.
- `job_enc` in 1: 1 = encrypt, 0 = decrypt.
- `job_rekey` in 1: 1 = write the key bytes and the config register; 0 = reuse the key already in the core.
- `res_valid` out 1: result held until accepted.
- `res_ready` in 1: result accepted.
- `res_data` out 128: result block, same byte order as `job_plain`.
- `res_err` out 1: timeout flag, qualified by `res_valid`.
- `busy` out 1: high in every state except IDLE.
- `ADDR` out 7: core register address.
- `DIN` out 8: core write data.
- `WR` out 1: core write strobe, one byte per cycle.
- `START` out 1: one-cycle run pulse.
- `OK` in 1: core done level.
- `DOUT` in 8: core read data; it is registered inside the core, so it is valid the cycle after `ADDR` is presented with `WR=0`.

## Operation

Core register map:
- 0–15: data in.
- 16–31: data out.
- 32–63: key.
- 64: control; bit0 = enc.
- 65: config; bits[1:0] = keylen.

FSM states and transitions:
- IDLE: when `job_valid` is high, latch all `job_*` inputs and go to LD_DATA.
- LD_DATA: 16 cycles writing addresses 0..15 with plain bytes 0..15. Then go to LD_KEY if the latched rekey is 1, otherwise to WR_CTRL.
- LD_KEY: 32 cycles writing addresses 32..63 with key bytes 0..31. All 32 bytes are always written, whatever keylen is.
- WR_CTRL: write `{7'b0, enc}` to address 64.
- WR_CFG: write `{6'b0, keylen}` to address 65. This state is visited only when rekey is 1; otherwise WR_CTRL goes straight to GO.
- GO: `START=1`, `WR=0`, for one cycle.
- WAIT_LO: wait until `OK` is sampled 0. A stale `OK` left high by the previous job is ignored.
- WAIT_HI: wait until `OK` is sampled 1.
- RD: 17 cycles. `ADDR` steps 16..31 with `WR=0`; `DOUT` is captured one cycle later into `res_data` byte (`ADDR`−16).
- DONE: `res_valid=1` until `res_ready`, then return to IDLE.

Timeout:
- A counter clears on entry to WAIT_LO and increments every cycle in WAIT_LO or WAIT_HI.
- When it reaches `TIMEOUT`, go to DONE with `res_err=1` and `res_data` unchanged from the previous job. RD is skipped.

Other rules:
- `DIN` and `ADDR` are don't-care whenever `WR=0`, except `ADDR` during RD.
- `job_valid` outside IDLE is ignored; the job is not queued.

## Timing

Reset values:
- `ADDR`=0, `DIN`=0, `WR`=0, `START`=0.
- `res_valid`=0, `res_err`=0, `res_data`=0, `busy`=0.
- `job_ready`=1 (decoded from state IDLE).

All bus outputs are registered. Cycle 0 is the IDLE cycle in which `job_valid` is sampled high; cycle n is n clocks later.
- rekey=1: writes in cycles 1–48, control in 49, config in 50, `START` in 51.
- rekey=0: control in 17, `START` in 18.
- After `OK` is sampled high in cycle T: `ADDR`=16 in T+1, last capture in T+17, `res_valid` high in T+18.
- `res_valid` and `res_ready` both high in a cycle: the result is consumed and the FSM is in IDLE next cycle.
- `RSTB` low at any time, including mid-job: all outputs return to reset values immediately. `WR` and `START` must never glitch high during or on exit from reset.

## Test plan

- Encrypt, rekey=1: plain=128'h1234567890ABCDEF01234567899ABCDE, key=256'h112233445566778899AABBCCDDEEFF00, keylen=3, core model raises `OK` 20 cycles after `START`. Required: 48 writes in order (addresses 0..15 then 32..63), 8'h01 to address 64 in cycle 49, 8'h03 to address 65 in cycle 50, `START` in cycle 51, `res_data` equal to the model's output bytes, `res_err`=0.
- Second job, rekey=0, enc=0: no writes to 32..65 except 8'h00 to address 64 in cycle 17; `START` in cycle 18.
- Stale `OK` held high from the previous job until 5 cycles after `START`: the controller does not read back until `OK` has fallen and risen again.
- `OK` never rises, `TIMEOUT`=1023: `res_valid` with `res_err`=1 exactly 1023 cycles after entry to WAIT_LO; no RD addresses issued.
- `res_ready` held low for 10 cycles: `res_valid` and `res_data` stay stable; `job_ready` stays 0 until the handshake completes.
- `RSTB` pulsed low during LD_KEY (cycle 30): `WR`=0 and `busy`=0 immediately, `job_ready`=1 after release; a new job then completes normally.
